// File: rtl/zero_run_detector.sv
// Per-channel zero-run tracker with idle/wake hysteresis, aggregated under a live
// channel mask into a global mute flag with one-cycle sleep/wake pulses.
module zero_run_detector #(
    parameter int NCH        = 2,
    parameter int DW         = 16,
    parameter int ZERO_LIMIT = 800,
    parameter int WAKE_LIMIT = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic [NCH*DW-1:0] data,
    input  logic [NCH-1:0]    ch_mask,
    output logic [NCH-1:0]    ch_zero,
    output logic              all_zeros,
    output logic              sleep_pulse,
    output logic              wake_pulse
);

    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    localparam int WW = $clog2(WAKE_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);
    localparam logic [WW-1:0] WLIM = WW'(WAKE_LIMIT);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_IDLE   = 1'b1
    } ch_state_e;

    // Handshake: enable is a valid-only strobe with no back-pressure; each rising
    // edge with enable=1 (and clear=0) consumes exactly one sample per channel.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ch_state_e      state_q, state_d;
        logic [ZW-1:0]  zcnt_q, zcnt_d;
        logic [WW-1:0]  wcnt_q, wcnt_d;
        logic           is_zero;

        assign is_zero = (data[k*DW +: DW] == '0);

        always_comb begin
            state_d = state_q;
            zcnt_d  = zcnt_q;
            wcnt_d  = wcnt_q;
            if (enable) begin
                if (state_q == ST_ACTIVE) begin
                    if (is_zero) begin
                        zcnt_d = zcnt_q + 1'b1;
                        if (zcnt_d == ZLIM) begin
                            state_d = ST_IDLE;
                            wcnt_d  = '0;
                        end
                    end else begin
                        zcnt_d = '0;
                    end
                end else begin
                    // Any zero inside a wake attempt restarts the non-zero run.
                    if (!is_zero) begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_d == WLIM) begin
                            state_d = ST_ACTIVE;
                            zcnt_d  = '0;
                        end
                    end else begin
                        wcnt_d = '0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (clear) begin
                state_q <= ST_ACTIVE;
                zcnt_q  <= '0;
                wcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                zcnt_q  <= zcnt_d;
                wcnt_q  <= wcnt_d;
            end
        end

        // The idle flag is the channel's FSM state bit, so it doubles as its debug view.
        assign ch_zero[k] = (state_q == ST_IDLE);
    end

    logic all_zeros_d, all_zeros_q;

    assign all_zeros   = (|ch_mask) & (&(ch_zero | ~ch_mask));
    assign all_zeros_d = all_zeros;

    always_ff @(posedge clk) begin
        if (clear) begin
            all_zeros_q <= 1'b0;
        end else begin
            all_zeros_q <= all_zeros_d;
        end
    end

    assign sleep_pulse = all_zeros & ~all_zeros_q;
    assign wake_pulse  = ~all_zeros & all_zeros_q;

endmodule

// File: tb/tb_zero_run_detector.sv
// Bench for zero_run_detector: two instances (WAKE_LIMIT 1 and 3) share stimulus and
// are compared each step against a run-length reference model.
module tb_zero_run_detector;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int ZL  = 800;
  localparam int WL_A = 1;
  localparam int WL_B = 3;

  logic              clk;
  logic              clear;
  logic              enable;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    ch_zero_a, ch_zero_b;
  logic              all_zeros_a, all_zeros_b;
  logic              sleep_pulse_a, sleep_pulse_b;
  logic              wake_pulse_a, wake_pulse_b;
  logic [4:0]        obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  // reference model: trailing run lengths per channel, idle flag per instance/channel
  int zrun [NCH];
  int nrun [NCH];
  bit idle [2][NCH];
  bit prev [2];
  int wl   [2];

  zero_run_detector #(.NCH(NCH), .DW(DW), .ZERO_LIMIT(ZL), .WAKE_LIMIT(WL_A)) u_dut_a (
    .clk(clk), .clear(clear), .enable(enable), .data(data), .ch_mask(ch_mask),
    .ch_zero(ch_zero_a), .all_zeros(all_zeros_a),
    .sleep_pulse(sleep_pulse_a), .wake_pulse(wake_pulse_a)
  );

  zero_run_detector #(.NCH(NCH), .DW(DW), .ZERO_LIMIT(ZL), .WAKE_LIMIT(WL_B)) u_dut_b (
    .clk(clk), .clear(clear), .enable(enable), .data(data), .ch_mask(ch_mask),
    .ch_zero(ch_zero_b), .all_zeros(all_zeros_b),
    .sleep_pulse(sleep_pulse_b), .wake_pulse(wake_pulse_b)
  );

  assign obs_a = {ch_zero_a, all_zeros_a, sleep_pulse_a, wake_pulse_a};
  assign obs_b = {ch_zero_b, all_zeros_b, sleep_pulse_b, wake_pulse_b};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_all(input int d);
    bit r;
    r = (ch_mask != '0);
    for (int k = 0; k < NCH; k++) if (ch_mask[k] && !idle[d][k]) r = 1'b0;
    return r;
  endfunction

  function automatic logic [4:0] exp_vec(input int d);
    bit a;
    a = model_all(d);
    return {idle[d][1], idle[d][0], a, a & ~prev[d], ~a & prev[d]};
  endfunction

  // driver: apply one cycle of inputs, advance the model across the edge
  task automatic step(input bit clr, input bit en, input logic [15:0] d0, input logic [15:0] d1);
    bit pre_all [2];
    logic [15:0] s;
    clear  = clr;
    enable = en;
    data   = {d1, d0};
    for (int d = 0; d < 2; d++) pre_all[d] = model_all(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) prev[d] = clr ? 1'b0 : pre_all[d];
    if (clr) begin
      for (int k = 0; k < NCH; k++) begin
        zrun[k] = 0;
        nrun[k] = 0;
        for (int d = 0; d < 2; d++) idle[d][k] = 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NCH; k++) begin
        s = (k == 0) ? d0 : d1;
        if (s == 16'h0) begin
          zrun[k]++;
          nrun[k] = 0;
        end else begin
          nrun[k]++;
          zrun[k] = 0;
        end
        for (int d = 0; d < 2; d++) begin
          if (!idle[d][k] && zrun[k] == ZL) idle[d][k] = 1'b1;
          else if (idle[d][k] && nrun[k] == wl[d]) idle[d][k] = 1'b0;
        end
      end
    end
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    ch_mask = 2'b11;
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'h0, 16'h0);
    checks++;
    if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%b b=%b want 00000", obs_a, obs_b);
    end
  endtask

  task automatic test_enter_idle();
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= ZL + 1; i++) begin
      step(1'b0, 1'b1, 16'h0, 16'h0);
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL enter_idle #%0d: got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (i == ZL - 1) begin
        checks++;
        if (all_zeros_a !== 1'b0) begin
          errors++;
          $display("FAIL enter_idle_799: all_zeros got %b want 0", all_zeros_a);
        end
      end
      if (i == ZL) begin
        checks++;
        if (ch_zero_a !== 2'b11 || all_zeros_a !== 1'b1 || sleep_pulse_a !== 1'b1) begin
          errors++;
          $display("FAIL enter_idle_800: got ch_zero=%b all=%b sleep=%b want 11 1 1", ch_zero_a, all_zeros_a, sleep_pulse_a);
        end
      end
      if (i == ZL + 1) begin
        checks++;
        if (sleep_pulse_a !== 1'b0) begin
          errors++;
          $display("FAIL sleep_one_cycle: sleep got %b want 0", sleep_pulse_a);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [15:0] seq [6];
    bit          want [6];
    seq  = '{16'h1234, 16'h00ff, 16'h0000, 16'h8000, 16'h0001, 16'hffff};
    want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, seq[i], 16'h0);
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1) || ch_zero_b[0] !== want[i]) begin
        errors++;
        $display("FAIL hysteresis #%0d: got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (wake_pulse_b !== 1'b1) begin
      errors++;
      $display("FAIL hyst_wake: wake_pulse got %b want 1", wake_pulse_b);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (wake_pulse_b !== 1'b0 || obs_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL hyst_wake_one_cycle: got b=%b want %b", obs_b, exp_vec(1));
    end
  endtask

  task automatic test_run_break();
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= 500 + 1 + ZL; i++) begin
      step(1'b0, 1'b1, (i == 501) ? 16'h0001 : 16'h0000, 16'h0000);
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL run_break #%0d: got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (i == 500 + ZL || i == 501 + ZL) begin
        checks++;
        if (ch_zero_a[0] !== (i == 501 + ZL)) begin
          errors++;
          $display("FAIL run_break_ch0 #%0d: ch_zero[0] got %b want %b", i, ch_zero_a[0], (i == 501 + ZL));
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= ZL; i++) begin
      step(1'b0, 1'b1, 16'h0, 16'h0);
      checks++;
      if (obs_a !== exp_vec(0) || ch_zero_a !== ((i == ZL) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL gaps_edge #%0d: got a=%b want %b", i, obs_a, exp_vec(0));
      end
      for (int g = 0; g < 5; g++) begin
        step(1'b0, 1'b0, 16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)));
        checks++;
        if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
          errors++;
          $display("FAIL gaps_hold #%0d.%0d: got a=%b b=%b want a=%b b=%b", i, g, obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
      end
    end
  endtask

  task automatic test_mask();
    step(1'b1, 1'b0, 16'h0, 16'h0);
    ch_mask = 2'b11;
    for (int i = 0; i < ZL; i++) step(1'b0, 1'b1, 16'h0, 16'($urandom_range(1, 65535)));
    step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (ch_zero_a !== 2'b01 || all_zeros_a !== 1'b0) begin
      errors++;
      $display("FAIL mask_11: got ch_zero=%b all=%b want 01 0", ch_zero_a, all_zeros_a);
    end
    ch_mask = 2'b01;
    #1;
    checks++;
    if (all_zeros_a !== 1'b1 || sleep_pulse_a !== 1'b1 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL mask_01: got all=%b sleep=%b want 1 1", all_zeros_a, sleep_pulse_a);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    ch_mask = 2'b00;
    #1;
    checks++;
    if (all_zeros_a !== 1'b0 || wake_pulse_a !== 1'b1 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL mask_00: got all=%b wake=%b want 0 1", all_zeros_a, wake_pulse_a);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    ch_mask = 2'b11;
  endtask

  task automatic test_clear_mid_run();
    bit saw_sleep;
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 599; i++) step(1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'h0, 16'h0);
    checks++;
    if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
      errors++;
      $display("FAIL clear_outputs: got a=%b b=%b want 00000", obs_a, obs_b);
    end
    saw_sleep = 1'b0;
    for (int i = 1; i <= ZL; i++) begin
      step(1'b0, 1'b1, 16'h0, 16'h0);
      if (i < ZL && sleep_pulse_a) saw_sleep = 1'b1;
      checks++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL clear_rerun #%0d: got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (saw_sleep || sleep_pulse_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_restart: early_sleep=%b sleep_at_800=%b want 0 1", saw_sleep, sleep_pulse_a);
    end
  endtask

  task automatic test_random();
    int mode [NCH];
    int len;
    logic [15:0] s [NCH];
    step(1'b1, 1'b0, 16'h0, 16'h0);
    for (int b = 0; b < 24; b++) begin
      len = $urandom_range(1, 900);
      for (int k = 0; k < NCH; k++) mode[k] = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < NCH; k++) begin
          case (mode[k])
            0:       s[k] = 16'h0;
            1:       s[k] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
            default: s[k] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
          endcase
        end
        if ($urandom_range(0, 63) == 0) ch_mask = 2'($urandom_range(0, 3));
        step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 3) != 0), s[0], s[1]);
        checks++;
        if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
          errors++;
          $display("FAIL random blk%0d #%0d: got a=%b b=%b want a=%b b=%b", b, i, obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
      end
    end
  endtask

  initial begin
    wl[0]   = WL_A;
    wl[1]   = WL_B;
    clear   = 1'b1;
    enable  = 1'b0;
    data    = '0;
    ch_mask = 2'b11;
    for (int k = 0; k < NCH; k++) begin
      zrun[k] = 0;
      nrun[k] = 0;
      for (int d = 0; d < 2; d++) idle[d][k] = 1'b0;
    end
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    test_reset();
    test_enter_idle();
    test_hysteresis();
    test_run_break();
    test_enable_gaps();
    test_mask();
    test_clear_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
